// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller signal bundle: hazard-detection inputs and pipeline control outputs.
// The slave modport is the controller; the master modport is the pipeline datapath driving it.
interface pipeline_hazard_ctrl_if;
   logic       start_i;
   logic       idex_memread_i;
   logic [4:0] idex_rd_i;
   logic [4:0] ifid_rs1_i;
   logic [4:0] ifid_rs2_i;
   logic       branch_taken_i;
   logic       dmem_req_i;
   logic       dmem_ack_i;
   logic       pc_write_o;
   logic       ifid_write_o;
   logic       ifid_flush_o;
   logic       idex_bubble_o;
   logic       pipe_stall_o;
   logic       dmem_start_o;
   logic [1:0] state_o;

   modport slave (
      input  start_i, idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
             branch_taken_i, dmem_req_i, dmem_ack_i,
      output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
             pipe_stall_o, dmem_start_o, state_o
   );

   modport master (
      output start_i, idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
             branch_taken_i, dmem_req_i, dmem_ack_i,
      input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
             pipe_stall_o, dmem_start_o, state_o
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: IDLE/RUN/MEM_WAIT FSM with load-use stall and branch flush.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipeline_hazard_ctrl (
   input  logic                 clk_i,
   input  logic                 rst_i,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]          stall_cnt_o,
   output logic [15:0]          flush_cnt_o,
`endif
   pipeline_hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      RUN      = 2'b01,
      MEM_WAIT = 2'b10
   } state_e;

   state_e state_q, state_d;

   logic load_use;
   logic pc_write;
   logic ifid_write;
   logic ifid_flush;
   logic idex_bubble;
   logic pipe_stall;
   logic dmem_start;

   assign load_use = bus.idex_memread_i && (bus.idex_rd_i != 5'd0) &&
                     ((bus.idex_rd_i == bus.ifid_rs1_i) || (bus.idex_rd_i == bus.ifid_rs2_i));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_stall  = 1'b1;
      dmem_start  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start_i) state_d = RUN;
         end
         RUN: begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            pipe_stall = 1'b0;
            // A memory request outranks the hazard: the pipeline freezes in MEM_WAIT and
            // re-presents the hazard afterwards, so no bubble is inserted here.
            if (bus.dmem_req_i) begin
               dmem_start = 1'b1;
               state_d    = MEM_WAIT;
            end else begin
               if (!bus.start_i) state_d = IDLE;
               if (load_use) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end else if (bus.branch_taken_i) begin
                  ifid_flush = 1'b1;
               end
            end
         end
         MEM_WAIT: begin
            if (bus.dmem_ack_i) state_d = bus.start_i ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.pc_write_o    = pc_write;
   assign bus.ifid_write_o  = ifid_write;
   assign bus.ifid_flush_o  = ifid_flush;
   assign bus.idex_bubble_o = idex_bubble;
   assign bus.pipe_stall_o  = pipe_stall;
   assign bus.dmem_start_o  = dmem_start;
   assign bus.state_o       = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if ((state_q != IDLE) && !pc_write && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (ifid_flush && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; inputs change and outputs are
// sampled around the falling edge, state advances on the rising edge.
module tb_pipeline_hazard_ctrl;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   checks = 0;
   int   failures = 0;

   pipeline_hazard_ctrl_if bus ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_o;
   logic [15:0] flush_cnt_o;
`endif

   pipeline_hazard_ctrl dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
`ifdef HAZARD_PERF_CNT_EN
      .stall_cnt_o (stall_cnt_o),
      .flush_cnt_o (flush_cnt_o),
`endif
      .bus         (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic clear_inputs();
      bus.idex_memread_i = 1'b0;
      bus.idex_rd_i      = 5'd0;
      bus.ifid_rs1_i     = 5'd0;
      bus.ifid_rs2_i     = 5'd0;
      bus.branch_taken_i = 1'b0;
      bus.dmem_req_i     = 1'b0;
      bus.dmem_ack_i     = 1'b0;
   endtask

   // Reset with start low, then release and start so the DUT sits in RUN at a falling edge.
   task automatic reset_and_run();
      @(negedge clk_i);
      rst_i = 1'b0;
      bus.start_i = 1'b0;
      clear_inputs();
      @(negedge clk_i);
      rst_i = 1'b1;
      bus.start_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      bus.start_i = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk_i);
      #1;
      checks++; if (bus.state_o !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", bus.state_o); end
      checks++; if (bus.pc_write_o !== 1'b0) begin failures++; $display("FAIL reset_pc_write got=%b exp=0", bus.pc_write_o); end
      checks++; if (bus.ifid_write_o !== 1'b0) begin failures++; $display("FAIL reset_ifid_write got=%b exp=0", bus.ifid_write_o); end
      checks++; if (bus.pipe_stall_o !== 1'b1) begin failures++; $display("FAIL reset_pipe_stall got=%b exp=1", bus.pipe_stall_o); end
      checks++; if ({bus.ifid_flush_o, bus.idex_bubble_o, bus.dmem_start_o} !== 3'b000) begin
         failures++; $display("FAIL reset_misc got=%b exp=000", {bus.ifid_flush_o, bus.idex_bubble_o, bus.dmem_start_o}); end
`ifdef HAZARD_PERF_CNT_EN
      checks++; if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 16'd0) begin
         failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
`endif
      $display("test_reset done");
   endtask

   task automatic test_start();
      @(negedge clk_i);
      rst_i = 1'b1;
      bus.start_i = 1'b1;
      #1;
      checks++; if (bus.state_o !== 2'b00) begin failures++; $display("FAIL start_before_edge got=%b exp=00", bus.state_o); end
      @(negedge clk_i); #1;
      checks++; if (bus.state_o !== 2'b01) begin failures++; $display("FAIL start_state got=%b exp=01", bus.state_o); end
      checks++; if (bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1) begin
         failures++; $display("FAIL start_writes got=%b%b exp=11", bus.pc_write_o, bus.ifid_write_o); end
      checks++; if (bus.pipe_stall_o !== 1'b0) begin failures++; $display("FAIL start_pipe_stall got=%b exp=0", bus.pipe_stall_o); end
      $display("test_start done");
   endtask

   task automatic test_load_use();
      int stall_cycles;
      stall_cycles = 0;
      @(negedge clk_i);
      bus.idex_memread_i = 1'b1; bus.idex_rd_i = 5'd5; bus.ifid_rs1_i = 5'd3; bus.ifid_rs2_i = 5'd5;
      #1;
      checks++; if (bus.pc_write_o !== 1'b0 || bus.ifid_write_o !== 1'b0 || bus.idex_bubble_o !== 1'b1) begin
         failures++; $display("FAIL load_use_rs2 got pc=%b ifid=%b bub=%b exp 0 0 1",
                              bus.pc_write_o, bus.ifid_write_o, bus.idex_bubble_o); end
      if (bus.pc_write_o === 1'b0) stall_cycles++;
      // The bubble moves into ID/EX, so the hazard is gone next cycle.
      @(negedge clk_i);
      bus.idex_memread_i = 1'b0;
      #1;
      if (bus.pc_write_o === 1'b0) stall_cycles++;
      checks++; if (stall_cycles !== 1) begin failures++; $display("FAIL load_use_stall_len got=%0d exp=1", stall_cycles); end
      checks++; if (bus.idex_bubble_o !== 1'b0) begin failures++; $display("FAIL load_use_release got=%b exp=0", bus.idex_bubble_o); end
      @(negedge clk_i);
      bus.idex_memread_i = 1'b1; bus.idex_rd_i = 5'd9; bus.ifid_rs1_i = 5'd9; bus.ifid_rs2_i = 5'd1;
      #1;
      checks++; if (bus.idex_bubble_o !== 1'b1) begin failures++; $display("FAIL load_use_rs1 got=%b exp=1", bus.idex_bubble_o); end
      @(negedge clk_i);
      bus.idex_rd_i = 5'd0; bus.ifid_rs1_i = 5'd0; bus.ifid_rs2_i = 5'd0;
      #1;
      checks++; if (bus.pc_write_o !== 1'b1 || bus.idex_bubble_o !== 1'b0) begin
         failures++; $display("FAIL load_use_x0 got pc=%b bub=%b exp 1 0", bus.pc_write_o, bus.idex_bubble_o); end
      @(negedge clk_i);
      bus.idex_rd_i = 5'd7; bus.ifid_rs1_i = 5'd7; bus.idex_memread_i = 1'b0;
      #1;
      checks++; if (bus.pc_write_o !== 1'b1) begin failures++; $display("FAIL non_load_no_stall got=%b exp=1", bus.pc_write_o); end
      clear_inputs();
      $display("test_load_use done");
   endtask

   task automatic test_branch_priority();
      @(negedge clk_i);
      bus.idex_memread_i = 1'b1; bus.idex_rd_i = 5'd4; bus.ifid_rs1_i = 5'd4;
      bus.branch_taken_i = 1'b1;
      #1;
      checks++; if (bus.ifid_flush_o !== 1'b0 || bus.idex_bubble_o !== 1'b1) begin
         failures++; $display("FAIL branch_vs_hazard got flush=%b bub=%b exp 0 1", bus.ifid_flush_o, bus.idex_bubble_o); end
      @(negedge clk_i);
      bus.idex_memread_i = 1'b0;
      #1;
      checks++; if (bus.ifid_flush_o !== 1'b1 || bus.pc_write_o !== 1'b1 || bus.idex_bubble_o !== 1'b0) begin
         failures++; $display("FAIL branch_flush got flush=%b pc=%b bub=%b exp 1 1 0",
                              bus.ifid_flush_o, bus.pc_write_o, bus.idex_bubble_o); end
      clear_inputs();
      @(negedge clk_i); #1;
      checks++; if (bus.ifid_flush_o !== 1'b0) begin failures++; $display("FAIL branch_clear got=%b exp=0", bus.ifid_flush_o); end
      $display("test_branch_priority done");
   endtask

   task automatic test_mem_wait();
      int start_pulses;
      start_pulses = 0;
      @(negedge clk_i);
      bus.dmem_ack_i = 1'b1;
      #1;
      checks++; if (bus.state_o !== 2'b01) begin failures++; $display("FAIL ack_outside_wait got=%b exp=01", bus.state_o); end
      @(negedge clk_i);
      bus.dmem_ack_i = 1'b0;
      bus.dmem_req_i = 1'b1;
      #1;
      checks++; if (bus.dmem_start_o !== 1'b1) begin failures++; $display("FAIL dmem_start got=%b exp=1", bus.dmem_start_o); end
      start_pulses += int'(bus.dmem_start_o);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk_i);
         bus.dmem_req_i = 1'b0;
         bus.dmem_ack_i = (c == 4);
         #1;
         start_pulses += int'(bus.dmem_start_o);
         checks++; if (bus.state_o !== 2'b10 || bus.pipe_stall_o !== 1'b1 || bus.pc_write_o !== 1'b0) begin
            failures++; $display("FAIL mem_wait_cycle%0d got st=%b stall=%b pc=%b exp 10 1 0",
                                 c, bus.state_o, bus.pipe_stall_o, bus.pc_write_o); end
      end
      @(negedge clk_i);
      bus.dmem_ack_i = 1'b0;
      #1;
      checks++; if (bus.state_o !== 2'b01) begin failures++; $display("FAIL mem_wait_return got=%b exp=01", bus.state_o); end
      checks++; if (start_pulses !== 1) begin failures++; $display("FAIL dmem_start_pulses got=%0d exp=1", start_pulses); end
      $display("test_mem_wait done");
   endtask

   task automatic test_req_with_hazard();
      @(negedge clk_i);
      bus.dmem_req_i = 1'b1;
      bus.idex_memread_i = 1'b1; bus.idex_rd_i = 5'd6; bus.ifid_rs2_i = 5'd6;
      #1;
      checks++; if (bus.dmem_start_o !== 1'b1 || bus.idex_bubble_o !== 1'b0) begin
         failures++; $display("FAIL req_hazard got start=%b bub=%b exp 1 0", bus.dmem_start_o, bus.idex_bubble_o); end
      @(negedge clk_i);
      bus.dmem_req_i = 1'b0;
      bus.start_i = 1'b0;
      bus.dmem_ack_i = 1'b1;
      #1;
      checks++; if (bus.state_o !== 2'b10 || bus.idex_bubble_o !== 1'b0) begin
         failures++; $display("FAIL req_hazard_wait got st=%b bub=%b exp 10 0", bus.state_o, bus.idex_bubble_o); end
      @(negedge clk_i);
      clear_inputs();
      #1;
      checks++; if (bus.state_o !== 2'b00) begin failures++; $display("FAIL ack_to_idle got=%b exp=00", bus.state_o); end
      $display("test_req_with_hazard done");
   endtask

   task automatic test_reset_mid_wait();
      reset_and_run();
      bus.dmem_req_i = 1'b1;
      @(negedge clk_i);
      bus.dmem_req_i = 1'b0;
      #1;
      checks++; if (bus.state_o !== 2'b10) begin failures++; $display("FAIL pre_reset_wait got=%b exp=10", bus.state_o); end
      #1 rst_i = 1'b0;
      #1;
      checks++; if (bus.state_o !== 2'b00 || bus.pipe_stall_o !== 1'b1) begin
         failures++; $display("FAIL async_reset got st=%b stall=%b exp 00 1", bus.state_o, bus.pipe_stall_o); end
      @(negedge clk_i);
      rst_i = 1'b1;
      bus.start_i = 1'b0;
      bus.dmem_ack_i = 1'b1;
      #1;
      checks++; if (bus.state_o !== 2'b00 || bus.dmem_start_o !== 1'b0) begin
         failures++; $display("FAIL ack_after_reset got st=%b start=%b exp 00 0", bus.state_o, bus.dmem_start_o); end
      @(negedge clk_i);
      bus.dmem_ack_i = 1'b0;
      #1;
      checks++; if (bus.state_o !== 2'b00) begin failures++; $display("FAIL ack_discarded got=%b exp=00", bus.state_o); end
      $display("test_reset_mid_wait done");
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf_counters();
      reset_and_run();
      for (int h = 0; h < 3; h++) begin
         bus.idex_memread_i = 1'b1; bus.idex_rd_i = 5'd5; bus.ifid_rs2_i = 5'd5;
         @(negedge clk_i);
         clear_inputs();
         @(negedge clk_i);
      end
      for (int b = 0; b < 2; b++) begin
         bus.branch_taken_i = 1'b1;
         @(negedge clk_i);
         clear_inputs();
         @(negedge clk_i);
      end
      bus.dmem_req_i = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk_i);
         bus.dmem_req_i = 1'b0;
         bus.dmem_ack_i = (c == 4);
      end
      @(negedge clk_i);
      clear_inputs();
      #1;
      checks++; if (stall_cnt_o !== 32'd7) begin failures++; $display("FAIL stall_cnt got=%0d exp=7", stall_cnt_o); end
      checks++; if (flush_cnt_o !== 16'd2) begin failures++; $display("FAIL flush_cnt got=%0d exp=2", flush_cnt_o); end
      $display("test_perf_counters done");
   endtask
`endif

   initial begin
      bus.start_i = 1'b0;
      clear_inputs();
      test_reset();
      test_start();
      test_load_use();
      test_branch_priority();
      test_mem_wait();
      test_req_with_hazard();
      test_reset_mid_wait();
`ifdef HAZARD_PERF_CNT_EN
      test_perf_counters();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 clk_i  input  1  system clock; all state updates on rising edge.
REQ-002 rst_i  input  1  reset, asynchronous, active-low.
REQ-003 start_i  input  1  run enable from top level; low holds the pipeline idle.
REQ-004 idex_memread_i  input  1  ID/EX instruction is a load (Mem[0] of the decode control word).
REQ-005 idex_rd_i  input  5  ID/EX destination register.
REQ-006 ifid_rs1_i, ifid_rs2_i  input  5 each  IF/ID source registers.
REQ-007 branch_taken_i  input  1  ID-stage branch resolved taken.
REQ-008 dmem_req_i  input  1  EX/MEM instruction needs a multi-cycle data-memory access.
REQ-009 dmem_ack_i  input  1  data memory completion, one-cycle pulse.
REQ-010 pc_write_o  output  1  PC update enable.
REQ-011 ifid_write_o  output  1  IF/ID register write enable.
REQ-012 ifid_flush_o  output  1  zero the IF/ID instruction.
REQ-013 idex_bubble_o  output  1  force the ID/EX control word to zero (NOP).
REQ-014 pipe_stall_o  output  1  freeze the ID/EX, EX/MEM and MEM/WB registers.
REQ-015 dmem_start_o  output  1  one-cycle request pulse to data memory.
REQ-016 state_o  output  2  current FSM state: IDLE=00, RUN=01, MEM_WAIT=10.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and MEM_WAIT, with state held in one registered 2-bit variable.
REQ-018 IDLE -> RUN on a cycle with start_i=1; in IDLE, pc_write_o=ifid_write_o=0, pipe_stall_o=1, and all other outputs are 0.
REQ-019 RUN with start_i=0 -> IDLE next cycle, unless dmem_req_i=1 that cycle.
REQ-020 RUN with dmem_req_i=1: dmem_start_o=1 for that cycle only, and next state is MEM_WAIT.
REQ-021 MEM_WAIT: pc_write_o=0, ifid_write_o=0, pipe_stall_o=1; dmem_start_o is not reasserted.
REQ-022 On dmem_ack_i=1 in MEM_WAIT, next state is RUN if start_i=1, else IDLE.
REQ-023 dmem_ack_i SHALL be ignored outside MEM_WAIT.
REQ-024 Load-use hazard: idex_memread_i=1, idex_rd_i!=0, and idex_rd_i equal to ifid_rs1_i or ifid_rs2_i.
REQ-025 Load-use response in RUN, combinational, same cycle: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; single-cycle stall.
REQ-026 branch_taken_i in RUN with no hazard: ifid_flush_o=1 and pc_write_o=1, same cycle.
REQ-027 Priority: MEM_WAIT/dmem_req_i > load-use > branch flush.
REQ-028 Load-use and branch_taken_i in the same cycle: stall wins and the flush is suppressed; the branch is re-evaluated next cycle.
REQ-029 dmem_req_i with a hazard in the same RUN cycle: the MEM_WAIT transition and dmem_start_o occur; idex_bubble_o=0, because the frozen pipeline re-presents the hazard afterwards.
REQ-030 RUN with no event: pc_write_o=ifid_write_o=1; all others 0.

Reset
REQ-031 rst_i=0 SHALL force IDLE immediately, asynchronously, including mid-MEM_WAIT; a pending ack is discarded.
REQ-032 Reset output values are the IDLE values: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0, pipe_stall_o=1, dmem_start_o=0, state_o=00; counters are 0.

Configuration
REQ-033 Macro HAZARD_PERF_CNT_EN defined: add output stall_cnt_o[31:0] and output flush_cnt_o[15:0].
REQ-034 stall_cnt_o SHALL increment each cycle with state != IDLE and pc_write_o=0, saturating at all-ones.
REQ-035 flush_cnt_o SHALL increment each cycle with ifid_flush_o=1, saturating at all-ones.
REQ-036 Macro undefined: both counter ports and their registers are absent, and behaviour is otherwise identical.

Verification
REQ-037 Reset low, then start_i=1 -> state_o 00 -> 01 on the first edge; pc_write_o=1, pipe_stall_o=0.
REQ-038 idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5 -> exactly one cycle with pc_write_o=0 and idex_bubble_o=1; no stall when idex_rd_i=0.
REQ-039 dmem_req_i pulse, ack 4 cycles later -> dmem_start_o high for 1 cycle, state 10 for 4 cycles, then 01; pipe_stall_o=1 throughout the wait.
REQ-040 Hazard plus branch_taken_i in the same cycle -> ifid_flush_o=0, idex_bubble_o=1; next cycle with the hazard gone -> ifid_flush_o=1.
REQ-041 rst_i low during MEM_WAIT, then ack arrives after release -> state 00, ack ignored, dmem_start_o=0.
REQ-042 With HAZARD_PERF_CNT_EN: 3 load-use stalls plus a 4-cycle memory wait -> stall_cnt_o=7; 2 branch flushes -> flush_cnt_o=2.
